// File: rtl/bram_stream_reader_pkg.sv
// Shared constants, FSM state type and address helper for the BRAM stream reader.
package bram_stream_reader_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  // Counter values at the sweep boundaries; counters are one bit wider than the address.
  localparam logic [ADDR_W:0] CNT_END  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic logic [ADDR_W-1:0] bit_reverse(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < ADDR_W; i++) begin
      r[i] = a[ADDR_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/bram_stream_reader_if.sv
// Control, BRAM read port and output stream of the BRAM stream reader.
interface bram_stream_reader_if;
  import bram_stream_reader_pkg::*;

  logic                     i_start;
  logic                     i_bitrev;
  logic                     o_busy;
  logic                     o_done;
  logic                     o_rd_en;
  logic        [ADDR_W-1:0] o_rd_addr;
  logic        [DATA_W-1:0] i_rd_data;
  logic signed [DATA_W-1:0] o_data;
  logic                     o_valid;
  logic                     i_ready;
  logic                     o_last;

  // Reader side
  modport master (
    input  i_start, i_bitrev, i_rd_data, i_ready,
    output o_busy, o_done, o_rd_en, o_rd_addr, o_data, o_valid, o_last
  );

  // Environment side: controller, BRAM and stream consumer
  modport slave (
    output i_start, i_bitrev, i_rd_data, i_ready,
    input  o_busy, o_done, o_rd_en, o_rd_addr, o_data, o_valid, o_last
  );

endinterface

// File: rtl/bram_stream_reader_stream_fifo2.sv
// Two-entry register FIFO (head/tail) that soaks up BRAM read latency and stream stalls.
module bram_stream_reader_stream_fifo2
  import bram_stream_reader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] tail;
  logic [1:0]        cnt;

  // Head always holds the oldest word; a pop shifts tail into head.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) head <= din;
          else             tail <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          head <= tail;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd2) begin
            head <= tail;
            tail <= din;
          end else begin
            head <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = head;
  assign empty = (cnt == 2'd0);
  assign count = cnt;

  overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && cnt == 2'd2));

  underflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && cnt == 2'd0));

endmodule

// File: rtl/bram_stream_reader.sv
// Sweeps every BRAM address once (natural or bit-reversed order) and streams the words out.
module bram_stream_reader
  import bram_stream_reader_pkg::*;
(
  input logic                  i_clk,
  input logic                  i_rst_n,
  bram_stream_reader_if.master bus
);

  state_t            state;
  logic              busy;
  logic              done;
  logic              bitrev_q;
  logic [ADDR_W:0]   issue_cnt;
  logic [ADDR_W:0]   out_cnt;
  logic              inflight_p1;
  logic              rd_en;
  logic              pop;
  logic [2:0]        occ;
  logic [1:0]        fifo_cnt;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;

  assign pop = !fifo_empty && bus.i_ready;

  // Words held or on their way; a same-cycle pop frees a slot, which keeps 1 word/cycle.
  assign occ   = {1'b0, fifo_cnt} + {2'b00, inflight_p1};
  assign rd_en = (state == ST_RUN) && (issue_cnt != CNT_END) &&
                 (occ < (3'd2 + {2'b00, pop}));

  // Sweep control: start latch, issue/output counters and done/busy flags.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      bitrev_q  <= 1'b0;
      issue_cnt <= '0;
      out_cnt   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.i_start) begin
            state     <= ST_RUN;
            busy      <= 1'b1;
            bitrev_q  <= bus.i_bitrev;
            issue_cnt <= '0;
            out_cnt   <= '0;
          end
        end
        ST_RUN: begin
          if (rd_en) issue_cnt <= issue_cnt + 1'b1;
          if (issue_cnt == CNT_END) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (pop && out_cnt == CNT_LAST) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      if (pop) out_cnt <= out_cnt + 1'b1;
    end
  end

  // Read-latency tracker: marks that i_rd_data carries a requested word this cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) inflight_p1 <= 1'b0;
    else          inflight_p1 <= rd_en;
  end

  bram_stream_reader_stream_fifo2 u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (inflight_p1),
    .din   (bus.i_rd_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign bus.o_rd_en   = rd_en;
  assign bus.o_rd_addr = bitrev_q ? bit_reverse(issue_cnt[ADDR_W-1:0])
                                  : issue_cnt[ADDR_W-1:0];
  assign bus.o_valid   = !fifo_empty;
  assign bus.o_data    = fifo_dout;
  assign bus.o_last    = !fifo_empty && (out_cnt == CNT_LAST);
  assign bus.o_busy    = busy;
  assign bus.o_done    = done;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader: BRAM model preloaded with mem[i]=i, stream monitor,
// table of sweep scenarios, bit-reverse spot table and hand-written reset sequence.
module tb_bram_stream_reader;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;

  bram_stream_reader_if bus();

  bram_stream_reader dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: registered read, junk when not enabled
  logic [15:0] mem [512];
  logic [15:0] junk;
  always @(posedge clk) bus.i_rd_data <= bus.o_rd_en ? mem[bus.o_rd_addr] : junk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [8:0] rev9(input logic [8:0] a);
    logic [8:0] r;
    for (int i = 0; i < 9; i++) r[i] = a[8-i];
    return r;
  endfunction

  // Stream monitor
  logic [15:0] got_d[$];
  bit          got_l[$];
  int          got_c[$];
  int          rd_cnt;
  int          done_cnt;
  int          done_cyc;
  bit          mon_en = 1'b0;
  bit          pv = 1'b0;
  bit          pr = 1'b0;
  bit          pl = 1'b0;
  logic [15:0] pd = '0;

  // Sample between active edges: handshakes, reads issued, done pulses, hold-while-stalled
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (pv && !pr) begin
        check("hold_valid", 32'(bus.o_valid), 32'd1);
        check("hold_data", 32'($unsigned(bus.o_data)), 32'(pd));
        check("hold_last", 32'(bus.o_last), 32'(pl));
      end
      if (bus.o_valid && bus.i_ready) begin
        got_d.push_back($unsigned(bus.o_data));
        got_l.push_back(bus.o_last);
        got_c.push_back(cyc);
      end
      if (bus.o_rd_en) rd_cnt++;
      if (bus.o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    pv = rst_n && bus.o_valid;
    pr = bus.i_ready;
    pd = $unsigned(bus.o_data);
    pl = bus.o_last;
  end

  logic [15:0] rev_q[$];

  // mode 0: ready=1, mode 1: ready random 30%, mode 2: ready=0 for 20 cycles then 1
  task automatic run_sweep(input bit br, input int mode, input int restart_at,
                           input int exp_lat, input logic [15:0] exp_last);
    int  start_edge;
    int  n;
    int  bad;
    int  nlast;
    bit  pulsed;
    pulsed = 1'b0;
    got_d.delete(); got_l.delete(); got_c.delete();
    rd_cnt = 0; done_cnt = 0; done_cyc = -1;
    @(posedge clk); #1;
    bus.i_start  = 1'b1;
    bus.i_bitrev = br;
    bus.i_ready  = (mode != 2);
    start_edge   = cyc + 1;
    @(posedge clk); #1;
    bus.i_start  = 1'b0;
    bus.i_bitrev = ~br;
    n = 0;
    while (done_cnt == 0 && n < 4000) begin
      if (mode == 1) bus.i_ready = ($urandom_range(0, 99) < 30);
      else if (mode == 2) begin
        if (n == 20) begin
          check("stall_reads", 32'(rd_cnt), 32'd2);
          check("stall_rd_en", 32'(bus.o_rd_en), 32'd0);
        end
        bus.i_ready = (n >= 20);
      end
      if (restart_at >= 0 && !pulsed && got_d.size() == restart_at) begin
        bus.i_start = 1'b1;
        pulsed = 1'b1;
      end else begin
        bus.i_start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.i_start = 1'b0;
    if (n >= 4000) check("done_timeout", 32'd1, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    check("word_count", 32'(got_d.size()), 32'd512);
    bad = 0; nlast = 0;
    for (int k = 0; k < got_d.size(); k++) begin
      logic [8:0] kk;
      logic [15:0] exp;
      kk  = 9'(k);
      exp = {7'd0, br ? rev9(kk) : kk};
      if (k >= 512 || got_d[k] !== exp) begin
        if (bad == 0) $display("first bad word at %0d: 0x%0h want 0x%0h", k, got_d[k], exp);
        bad++;
      end
      if (got_l[k]) nlast++;
    end
    check("order_errors", 32'(bad), 32'd0);
    check("last_count", 32'(nlast), 32'd1);
    if (got_d.size() >= 512) begin
      check("last_on_512th", 32'(got_l[511]), 32'd1);
      check("last_data", 32'(got_d[511]), 32'(exp_last));
      check("done_after_last", 32'(done_cyc), 32'(got_c[511] + 1));
      if (mode != 1) check("full_rate", 32'(got_c[511] - got_c[0]), 32'd511);
      if (exp_lat >= 0) check("first_latency", 32'(got_c[0] - start_edge), 32'(exp_lat));
    end
    check("reads_issued", 32'(rd_cnt), 32'd512);
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("busy_after", 32'(bus.o_busy), 32'd0);
    if (br) rev_q = got_d;
  endtask

  typedef struct {
    bit          bitrev;
    int          mode;
    int          restart_at;
    int          exp_lat;
    logic [15:0] exp_last;
  } sweep_t;

  typedef struct {
    int          idx;
    logic [15:0] exp;
  } spot_t;

  sweep_t sweeps[5];
  spot_t  spots[12];

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  32'(bus.o_busy),    32'd0);
    check({tag, "_done"},  32'(bus.o_done),    32'd0);
    check({tag, "_valid"}, 32'(bus.o_valid),   32'd0);
    check({tag, "_last"},  32'(bus.o_last),    32'd0);
    check({tag, "_rd_en"}, 32'(bus.o_rd_en),   32'd0);
    check({tag, "_data"},  32'($unsigned(bus.o_data)), 32'd0);
    check({tag, "_addr"},  32'(bus.o_rd_addr), 32'd0);
  endtask

  initial begin
    sweeps[0] = '{bitrev: 1'b0, mode: 0, restart_at: -1,  exp_lat: 2,  exp_last: 16'h01FF};
    sweeps[1] = '{bitrev: 1'b1, mode: 0, restart_at: -1,  exp_lat: 2,  exp_last: 16'h01FF};
    sweeps[2] = '{bitrev: 1'b0, mode: 1, restart_at: -1,  exp_lat: -1, exp_last: 16'h01FF};
    sweeps[3] = '{bitrev: 1'b0, mode: 2, restart_at: -1,  exp_lat: -1, exp_last: 16'h01FF};
    sweeps[4] = '{bitrev: 1'b0, mode: 0, restart_at: 100, exp_lat: 2,  exp_last: 16'h01FF};

    spots[0]  = '{idx: 0,   exp: 16'd0};
    spots[1]  = '{idx: 1,   exp: 16'd256};
    spots[2]  = '{idx: 2,   exp: 16'd128};
    spots[3]  = '{idx: 3,   exp: 16'd384};
    spots[4]  = '{idx: 4,   exp: 16'd64};
    spots[5]  = '{idx: 5,   exp: 16'd320};
    spots[6]  = '{idx: 6,   exp: 16'd192};
    spots[7]  = '{idx: 7,   exp: 16'd448};
    spots[8]  = '{idx: 8,   exp: 16'd32};
    spots[9]  = '{idx: 256, exp: 16'd1};
    spots[10] = '{idx: 510, exp: 16'd255};
    spots[11] = '{idx: 511, exp: 16'd511};

    for (int i = 0; i < 512; i++) mem[i] = 16'(i);
    junk         = 16'h0000;
    rst_n        = 1'b0;
    bus.i_start  = 1'b0;
    bus.i_bitrev = 1'b0;
    bus.i_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n  = 1'b1;
    mon_en = 1'b1;

    for (int s = 0; s < 5; s++) begin
      run_sweep(sweeps[s].bitrev, sweeps[s].mode, sweeps[s].restart_at,
                sweeps[s].exp_lat, sweeps[s].exp_last);
    end

    for (int s = 0; s < 12; s++) begin
      if (rev_q.size() > spots[s].idx) check("bitrev_spot", 32'(rev_q[spots[s].idx]), 32'(spots[s].exp));
      else check("bitrev_spot_missing", 32'(rev_q.size()), 32'd512);
    end

    // Reset in the middle of a sweep, then a fresh sweep with junk on the idle read bus
    got_d.delete(); got_l.delete(); got_c.delete();
    @(posedge clk); #1;
    bus.i_ready  = 1'b1;
    bus.i_bitrev = 1'b0;
    bus.i_start  = 1'b1;
    @(posedge clk); #1;
    bus.i_start  = 1'b0;
    for (int n = 0; n < 1000 && got_d.size() < 200; n++) begin
      @(posedge clk); #1;
    end
    check("reach_word_200", 32'(got_d.size() >= 200), 32'd1);
    rst_n = 1'b0;
    junk  = 16'hBEEF;
    @(posedge clk); #1;
    check_idle_outputs("midreset");
    rst_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      check("post_reset_valid", 32'(bus.o_valid), 32'd0);
    end
    run_sweep(1'b0, 0, -1, 2, 16'h01FF);
    check("junk_never_streamed", 32'(got_d.size() > 0 && got_d[0] == 16'hBEEF), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
